// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its two-client arbiter:
// opcode constants, arbiter state encoding, flag bundle and the legal-opcode check.
package alu_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned CNT_W = 4;

  localparam logic [OP_W-1:0] ADD  = 4'b0010;
  localparam logic [OP_W-1:0] SUB  = 4'b0011;
  localparam logic [OP_W-1:0] AND  = 4'b0100;
  localparam logic [OP_W-1:0] OR   = 4'b0101;
  localparam logic [OP_W-1:0] XOR  = 4'b0110;
  localparam logic [OP_W-1:0] NOTA = 4'b0111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    REJECT = 2'd2
  } state_t;

  typedef struct packed {
    logic cf;
    logic of;
    logic sf;
    logic zf;
  } alu_flags_t;

  // True for the opcodes the ALU implements.
  function automatic logic is_legal_op(input logic [OP_W-1:0] op);
    return op inside {ADD, SUB, AND, OR, XOR, NOTA};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter.
//   CLK, RST      : clock, synchronous active-high reset
//   req0, req1    : request lines
//   update        : advance the pointer past the current winner
//   grant_c       : one-hot grant (combinational from req and pointer)
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic       req0,
  input  logic       req1,
  input  logic       update,
  output logic [1:0] grant_c
);

  // High when client 1 wins a tie.
  logic prio1;

  always_comb begin
    grant_c = 2'b00;
    if (req0 && req1) begin
      grant_c = prio1 ? 2'b10 : 2'b01;
    end else begin
      grant_c = {req1, req0};
    end
  end

  // After granting client 0, client 1 wins the next tie, and vice versa.
  always_ff @(posedge CLK) begin
    if (RST) begin
      prio1 <= 1'b0;
    end else if (update) begin
      prio1 <= grant_c[0];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin scheduler sharing one registered ALU between two clients.
//   CLK, RST                 : clock, synchronous active-high reset
//   REQk, OPk, Ak, Bk        : client k request, opcode and operands
//   ACKk, DONEk              : one-cycle accept / completion pulses
//   RESULT, CF/OF/SF/ZF, ERR : result and flags of the last completion
//   BUSY                     : an operation is in flight or being rejected
//   ALU_EN/OE/OPCODE/A/B     : drive side of the ALU
//   ALU_OUT, ALU_CF/OF/SF/ZF : ALU result, valid ALU_LAT edges after EN is sampled
// ALU_LAT must lie in 1..15.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned ALU_LAT = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [OP_W-1:0]  OP0,
  input  logic [OP_W-1:0]  OP1,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             ACK0,
  output logic             ACK1,
  output logic             DONE0,
  output logic             DONE1,
  output logic [WIDTH-1:0] RESULT,
  output logic             CF,
  output logic             OF,
  output logic             SF,
  output logic             ZF,
  output logic             ERR,
  output logic             BUSY,
  output logic             ALU_EN,
  output logic             ALU_OE,
  output logic [OP_W-1:0]  ALU_OPCODE,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  input  logic [WIDTH-1:0] ALU_OUT,
  input  logic             ALU_CF,
  input  logic             ALU_OF,
  input  logic             ALU_SF,
  input  logic             ALU_ZF
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               cur;
  logic [1:0]         grant_c;
  logic               upd_c;
  logic [OP_W-1:0]    op_sel_c;
  logic [WIDTH-1:0]   a_sel_c;
  logic [WIDTH-1:0]   b_sel_c;
  alu_flags_t         alu_flags_c;

  // Requests only count while idle.
  assign upd_c = (state == IDLE) && (REQ0 || REQ1);

  rr_arb2 u_arb (
    .CLK     (CLK),
    .RST     (RST),
    .req0    (REQ0),
    .req1    (REQ1),
    .update  (upd_c),
    .grant_c (grant_c)
  );

  // Winner's payload.
  assign op_sel_c = grant_c[1] ? OP1 : OP0;
  assign a_sel_c  = grant_c[1] ? A1  : A0;
  assign b_sel_c  = grant_c[1] ? B1  : B0;

  assign alu_flags_c = '{cf: ALU_CF, of: ALU_OF, sf: ALU_SF, zf: ALU_ZF};

  // Scheduler FSM with registered outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      cur        <= 1'b0;
      ACK0       <= 1'b0;
      ACK1       <= 1'b0;
      DONE0      <= 1'b0;
      DONE1      <= 1'b0;
      RESULT     <= '0;
      CF         <= 1'b0;
      OF         <= 1'b0;
      SF         <= 1'b0;
      ZF         <= 1'b0;
      ERR        <= 1'b0;
      BUSY       <= 1'b0;
      ALU_EN     <= 1'b0;
      ALU_OE     <= 1'b0;
      ALU_OPCODE <= '0;
      ALU_A      <= '0;
      ALU_B      <= '0;
    end else begin
      ACK0   <= 1'b0;
      ACK1   <= 1'b0;
      DONE0  <= 1'b0;
      DONE1  <= 1'b0;
      ALU_EN <= 1'b0;
      unique case (state)
        IDLE: begin
          if (upd_c) begin
            cur  <= grant_c[1];
            ACK0 <= grant_c[0];
            ACK1 <= grant_c[1];
            BUSY <= 1'b1;
            if (is_legal_op(op_sel_c)) begin
              ALU_OPCODE <= op_sel_c;
              ALU_A      <= a_sel_c;
              ALU_B      <= b_sel_c;
              ALU_EN     <= 1'b1;
              ALU_OE     <= 1'b1;
              cnt        <= CNT_W'(ALU_LAT);
              state      <= WAIT;
            end else begin
              state <= REJECT;
            end
          end
        end
        WAIT: begin
          // The first WAIT edge is the one where the ALU samples EN;
          // latency is counted from there, so the counter holds on it.
          if (!ALU_EN) begin
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              RESULT <= ALU_OUT;
              CF     <= alu_flags_c.cf;
              OF     <= alu_flags_c.of;
              SF     <= alu_flags_c.sf;
              ZF     <= alu_flags_c.zf;
              ERR    <= 1'b0;
              DONE0  <= ~cur;
              DONE1  <= cur;
              ALU_OE <= 1'b0;
              BUSY   <= 1'b0;
              state  <= IDLE;
            end
          end
        end
        REJECT: begin
          ERR   <= 1'b1;
          DONE0 <= ~cur;
          DONE1 <= cur;
          BUSY  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU, transaction-timing reference model,
// per-cycle comparison, directed scenarios with literal expectations, random traffic.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned ALU_LAT = 2;

  logic             CLK = 1'b0;
  logic             RST;
  logic             REQ0, REQ1;
  logic [3:0]       OP0, OP1;
  logic [WIDTH-1:0] A0, B0, A1, B1;
  logic             ACK0, ACK1, DONE0, DONE1;
  logic [WIDTH-1:0] RESULT;
  logic             CF, OF, SF, ZF, ERR, BUSY;
  logic             ALU_EN, ALU_OE;
  logic [3:0]       ALU_OPCODE;
  logic [WIDTH-1:0] ALU_A, ALU_B, ALU_OUT;
  logic             ALU_CF, ALU_OF, ALU_SF, ALU_ZF;

  int checks = 0;
  int errors = 0;
  int tcyc   = 0;

  always #5 CLK = ~CLK;

  alu_arbiter #(.WIDTH(WIDTH), .ALU_LAT(ALU_LAT)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .REQ1(REQ1), .OP0(OP0), .OP1(OP1),
    .A0(A0), .B0(B0), .A1(A1), .B1(B1),
    .ACK0(ACK0), .ACK1(ACK1), .DONE0(DONE0), .DONE1(DONE1),
    .RESULT(RESULT), .CF(CF), .OF(OF), .SF(SF), .ZF(ZF), .ERR(ERR), .BUSY(BUSY),
    .ALU_EN(ALU_EN), .ALU_OE(ALU_OE), .ALU_OPCODE(ALU_OPCODE),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_OUT(ALU_OUT),
    .ALU_CF(ALU_CF), .ALU_OF(ALU_OF), .ALU_SF(ALU_SF), .ALU_ZF(ALU_ZF)
  );

  // ALU function, packed as {cf, of, sf, zf, result}.
  function automatic logic [WIDTH+3:0] alu_fn(input logic [3:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [WIDTH:0]   s;
    logic [WIDTH-1:0] r;
    logic             c, o;
    c = 1'b0;
    o = 1'b0;
    r = '0;
    case (op)
      ADD: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[WIDTH-1:0];
        c = s[WIDTH];
        o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      SUB: begin
        r = a - b;
        c = (a < b);
        o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      end
      AND:     r = a & b;
      OR:      r = a | b;
      XOR:     r = a ^ b;
      NOTA:    r = ~a;
      default: r = '0;
    endcase
    return {c, o, r[WIDTH-1], (r == '0), r};
  endfunction

  // Behavioural ALU: result appears ALU_LAT edges after EN is sampled.
  logic [WIDTH+3:0] alu_pipe [ALU_LAT];
  initial for (int i = 0; i < int'(ALU_LAT); i++) alu_pipe[i] = '0;
  always @(posedge CLK) begin
    if (ALU_EN) alu_pipe[0] <= alu_fn(ALU_OPCODE, ALU_A, ALU_B);
    for (int i = 1; i < int'(ALU_LAT); i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign {ALU_CF, ALU_OF, ALU_SF, ALU_ZF, ALU_OUT} = alu_pipe[ALU_LAT-1];

  // Reference model: timing expressed as edge numbers of grant and completion.
  typedef struct packed {
    logic             valid;
    logic             ack0, ack1, done0, done1, busy, en, oe, err;
    logic [WIDTH+3:0] flags_res;
    logic [3:0]       op;
    logic [WIDTH-1:0] a, b;
    logic             active, legal, cur, ptr;
    logic [WIDTH+3:0] pend;
    int unsigned      now, done_at, accept_ok;
  } model_t;

  model_t m = '0;

  function automatic model_t model_step(input model_t s, input logic rst,
                                        input logic r0, input logic r1,
                                        input logic [3:0] o0, input logic [3:0] o1,
                                        input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                                        input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1);
    model_t n;
    logic   w;
    logic [3:0] op;
    n = s;
    if (rst) begin
      n = '0;
      n.valid     = 1'b1;
      n.accept_ok = 1;
      return n;
    end
    n.now   = s.now + 1;
    n.ack0  = 1'b0;
    n.ack1  = 1'b0;
    n.done0 = 1'b0;
    n.done1 = 1'b0;
    n.en    = 1'b0;
    if (s.active && n.now == s.done_at) begin
      n.active = 1'b0;
      n.busy   = 1'b0;
      if (s.cur) n.done1 = 1'b1; else n.done0 = 1'b1;
      if (s.legal) begin
        n.flags_res = s.pend;
        n.err       = 1'b0;
        n.oe        = 1'b0;
      end else begin
        n.err = 1'b1;
      end
    end else if (!s.active && n.now >= s.accept_ok && (r0 || r1)) begin
      w = (r0 && r1) ? s.ptr : r1;
      n.ptr    = ~w;
      n.cur    = w;
      n.ack0   = ~w;
      n.ack1   = w;
      n.busy   = 1'b1;
      n.active = 1'b1;
      op = w ? o1 : o0;
      if (op >= 4'd2 && op <= 4'd7) begin
        n.legal     = 1'b1;
        n.en        = 1'b1;
        n.oe        = 1'b1;
        n.op        = op;
        n.a         = w ? a1 : a0;
        n.b         = w ? b1 : b0;
        n.pend      = alu_fn(op, n.a, n.b);
        n.done_at   = n.now + 1 + ALU_LAT;
        n.accept_ok = n.now + 2 + ALU_LAT;
      end else begin
        n.legal     = 1'b0;
        n.done_at   = n.now + 1;
        n.accept_ok = n.now + 2;
      end
    end
    return n;
  endfunction

  always @(posedge CLK)
    m <= model_step(m, RST, REQ0, REQ1, OP0, OP1, A0, B0, A1, B1);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, on the falling edge.
  always @(negedge CLK) begin
    if (m.valid === 1'b1) begin
      chk("ACK0",       32'(ACK0),       32'(m.ack0));
      chk("ACK1",       32'(ACK1),       32'(m.ack1));
      chk("DONE0",      32'(DONE0),      32'(m.done0));
      chk("DONE1",      32'(DONE1),      32'(m.done1));
      chk("BUSY",       32'(BUSY),       32'(m.busy));
      chk("ALU_EN",     32'(ALU_EN),     32'(m.en));
      chk("ALU_OE",     32'(ALU_OE),     32'(m.oe));
      chk("ERR",        32'(ERR),        32'(m.err));
      chk("ALU_OPCODE", 32'(ALU_OPCODE), 32'(m.op));
      chk("ALU_A",      32'(ALU_A),      32'(m.a));
      chk("ALU_B",      32'(ALU_B),      32'(m.b));
      chk("RESULT",     32'(RESULT),     32'(m.flags_res[WIDTH-1:0]));
      chk("FLAGS",      32'({CF, OF, SF, ZF}), 32'(m.flags_res[WIDTH+3:WIDTH]));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
    tcyc++;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return ACK0;
      1:       return ACK1;
      2:       return DONE0;
      3:       return DONE1;
      default: return ACK0 | ACK1;
    endcase
  endfunction

  // Bounded wait for a pulse; a timeout is a failed comparison.
  task automatic wait_for(input int sel, input string name, output int at);
    bit found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (sig(sel)) begin
        found = 1'b1;
        break;
      end
      step();
    end
    chk({name, "_seen"}, 32'(found), 32'd1);
    at = tcyc;
  endtask

  function automatic logic [3:0] rand_op();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(2, 7));
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int t_ack, t_done, t_prev;
    int order [6];
    RST = 1'b1;
    REQ0 = 1'b0; REQ1 = 1'b0;
    OP0 = '0; OP1 = '0;
    A0 = '0; B0 = '0; A1 = '0; B1 = '0;
    repeat (3) step();
    chk("reset_busy",   32'(BUSY),   32'd0);
    chk("reset_result", 32'(RESULT), 32'd0);
    RST = 1'b0;

    // SUB on client 1: 5 - 5.
    REQ1 = 1'b1; OP1 = SUB; A1 = 8'h05; B1 = 8'h05;
    wait_for(1, "sub_ack", t_ack);
    REQ1 = 1'b0;
    wait_for(3, "sub_done", t_done);
    chk("sub_result", 32'(RESULT), 32'h00);
    chk("sub_zf",     32'(ZF),     32'd1);
    chk("sub_cf",     32'(CF),     32'd0);

    // ADD on client 0: 7F + 01.
    step();
    REQ0 = 1'b1; OP0 = ADD; A0 = 8'h7F; B0 = 8'h01;
    wait_for(0, "add_ack", t_ack);
    REQ0 = 1'b0;
    wait_for(2, "add_done", t_done);
    chk("add_latency", 32'(t_done - t_ack), 32'd3);
    chk("add_result",  32'(RESULT), 32'h80);
    chk("add_flags",   32'({CF, OF, SF, ZF}), 32'b0110);
    chk("add_err",     32'(ERR), 32'd0);

    // Illegal opcode on client 1.
    step();
    REQ1 = 1'b1; OP1 = 4'hF;
    wait_for(1, "ill_ack", t_ack);
    REQ1 = 1'b0;
    chk("ill_en", 32'(ALU_EN), 32'd0);
    wait_for(3, "ill_done", t_done);
    chk("ill_latency", 32'(t_done - t_ack), 32'd1);
    chk("ill_err",     32'(ERR),    32'd1);
    chk("ill_result",  32'(RESULT), 32'h80);

    // Back-to-back on client 1 with REQ held.
    step();
    REQ1 = 1'b1; OP1 = XOR; A1 = 8'h3C; B1 = 8'h0F;
    wait_for(1, "b2b_ack", t_prev);
    for (int k = 0; k < 3; k++) begin
      OP1 = 4'($urandom_range(2, 7)); A1 = 8'($urandom); B1 = 8'($urandom);
      step();
      wait_for(1, "b2b_ack", t_ack);
      chk("b2b_spacing", 32'(t_ack - t_prev), 32'd4);
      t_prev = t_ack;
    end
    REQ1 = 1'b0;

    // Reset in the cycle after an accept discards the operation.
    repeat (6) step();
    REQ0 = 1'b1; OP0 = ADD; A0 = 8'h11; B0 = 8'h22;
    wait_for(0, "rst_ack", t_ack);
    REQ0 = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("rst_result", 32'(RESULT), 32'd0);
    chk("rst_busy",   32'(BUSY),   32'd0);
    chk("rst_oe",     32'(ALU_OE), 32'd0);
    chk("rst_err",    32'(ERR),    32'd0);
    chk("rst_done0",  32'(DONE0),  32'd0);

    // Fairness with both clients requesting continuously.
    REQ0 = 1'b1; OP0 = OR;  A0 = 8'h50; B0 = 8'h05;
    REQ1 = 1'b1; OP1 = AND; A1 = 8'hF0; B1 = 8'h3C;
    wait_for(4, "fair_ack", t_prev);
    order[0] = int'(ACK1);
    for (int k = 1; k < 6; k++) begin
      if (ACK1) begin A1 = 8'($urandom); B1 = 8'($urandom); end
      else      begin A0 = 8'($urandom); B0 = 8'($urandom); end
      step();
      wait_for(4, "fair_ack", t_ack);
      order[k] = int'(ACK1);
      chk("fair_spacing", 32'(t_ack - t_prev), 32'd4);
      t_prev = t_ack;
    end
    for (int k = 0; k < 6; k++) chk("fair_order", 32'(order[k]), 32'(k % 2));
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (6) step();

    // Random traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      if (REQ0 && ACK0) begin
        if ($urandom_range(0, 1) == 0) REQ0 = 1'b0;
        else begin OP0 = rand_op(); A0 = 8'($urandom); B0 = 8'($urandom); end
      end else if (!REQ0 && $urandom_range(0, 2) == 0) begin
        REQ0 = 1'b1; OP0 = rand_op(); A0 = 8'($urandom); B0 = 8'($urandom);
      end
      if (REQ1 && ACK1) begin
        if ($urandom_range(0, 1) == 0) REQ1 = 1'b0;
        else begin OP1 = rand_op(); A1 = 8'($urandom); B1 = 8'($urandom); end
      end else if (!REQ1 && $urandom_range(0, 2) == 0) begin
        REQ1 = 1'b1; OP1 = rand_op(); A1 = 8'($urandom); B1 = 8'($urandom);
      end
      RST = ($urandom_range(0, 199) == 0);
      step();
    end
    RST = 1'b0;
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (8) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
